// File: rtl/clkdiv_pkg.sv
// Shared constants, types and helpers for the clkdiv_bank divider slice.
package clkdiv_pkg;
  localparam int CNT_WIDTH_DEF = 27;

  typedef logic [CNT_WIDTH_DEF-1:0] cnt_t;

  function automatic int ch_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // A zero half-period would never terminate, so it is stored as one.
  function automatic logic [63:0] clamp_div(input logic [63:0] v);
    return (v == 64'd0) ? 64'd1 : v;
  endfunction
endpackage

// File: rtl/clkdiv_channel.sv
// One divider slice: counter, half-period, shadow divisor, toggle and tick.
// CLKDIV_IMMEDIATE_EN: writes load the half-period at once and restart the count.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 i_en,
  input  logic                 i_wr,
  input  logic [CNT_WIDTH-1:0] i_val,
  input  logic                 i_sync,
  output logic                 o_pend,
  output logic                 o_clk,
  output logic                 o_tick
);
  localparam logic [CNT_WIDTH-1:0] DEF_HP = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_hp;
  logic                 r_clk;
  logic                 r_tick;
  logic                 w_tc;

  // >= rather than ==: a shorter divisor applied while disabled must not strand the count.
  assign w_tc   = (r_cnt >= (r_hp - ONE));
  assign o_clk  = r_clk;
  assign o_tick = r_tick;

`ifdef CLKDIV_IMMEDIATE_EN
  assign o_pend = 1'b0;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_hp   <= DEF_HP;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (i_sync) begin
        r_cnt <= '0;
        r_clk <= 1'b0;
        if (i_wr) r_hp <= i_val;
      end else if (i_wr) begin
        r_cnt <= '0;
        r_hp  <= i_val;
      end else if (i_en) begin
        if (w_tc) begin
          r_cnt  <= '0;
          r_clk  <= ~r_clk;
          r_tick <= ~r_clk;
        end else begin
          r_cnt <= r_cnt + ONE;
        end
      end
    end
  end
`else
  logic [CNT_WIDTH-1:0] r_sh;
  logic                 r_pend;

  assign o_pend = r_pend;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_hp   <= DEF_HP;
      r_sh   <= DEF_HP;
      r_pend <= 1'b0;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (i_sync) begin
        r_cnt  <= '0;
        r_clk  <= 1'b0;
        r_pend <= 1'b0;
        if (r_pend) r_hp <= r_sh;
      end else begin
        if (i_en && w_tc) begin
          r_cnt  <= '0;
          r_clk  <= ~r_clk;
          r_tick <= ~r_clk;
        end else if (i_en) begin
          r_cnt <= r_cnt + ONE;
        end
        // A write landing on the apply cycle wins and stays pending.
        if (r_pend && !i_wr && (w_tc || !i_en)) begin
          r_hp   <= r_sh;
          r_pend <= 1'b0;
        end
      end
      if (i_wr) begin
        r_sh   <= i_val;
        r_pend <= 1'b1;
      end
    end
  end
`endif
endmodule

// File: rtl/clkdiv_bank.sv
// NUM_CH programmable 50% duty clock dividers with shared write port and global sync.
// CLKDIV_IMMEDIATE_EN selects immediate (unshadowed) divisor loading.
module clkdiv_bank
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int DEFAULT_DIV = 50_000_000
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             enable,
  input  logic                          div_wr,
  input  logic [ch_idx_w(NUM_CH)-1:0]   div_ch,
  input  logic [CNT_WIDTH-1:0]          div_value,
  input  logic                          sync_all,
  output logic [NUM_CH-1:0]             div_pending,
  output logic [NUM_CH-1:0]             clk_out,
  output logic [NUM_CH-1:0]             tick
);
  localparam int CH_W = ch_idx_w(NUM_CH);

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
    $error("clkdiv_bank: NUM_CH must be 1..16");
  end
  if (DEFAULT_DIV < 1 || 64'(DEFAULT_DIV) > ((64'd1 << CNT_WIDTH) - 64'd1)) begin : g_bad_div
    $error("clkdiv_bank: DEFAULT_DIV must be 1..2^CNT_WIDTH-1");
  end

  logic [NUM_CH-1:0]    w_wr;
  logic [CNT_WIDTH-1:0] w_val;

  assign w_val = CNT_WIDTH'(clamp_div(64'(div_value)));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // Channel indices at or beyond NUM_CH match no slice, so those writes drop.
    assign w_wr[c] = div_wr && (div_ch == CH_W'(c));

    clkdiv_channel #(
      .CNT_WIDTH   (CNT_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in (clk_in),
      .reset  (reset),
      .i_en   (enable[c]),
      .i_wr   (w_wr[c]),
      .i_val  (w_val),
      .i_sync (sync_all),
      .o_pend (div_pending[c]),
      .o_clk  (clk_out[c]),
      .o_tick (tick[c])
    );
  end
endmodule

// File: tb/tb_clkdiv_bank.sv
// Self-checking bench for clkdiv_bank: directed table, corner sequences, random vs model.
module tb_clkdiv_bank;
  localparam int NUM_CH      = 3;
  localparam int CNT_WIDTH   = 8;
  localparam int DEFAULT_DIV = 4;
  localparam int CH_W        = 2;

  logic                 clk_in = 1'b0;
  logic                 reset;
  logic [NUM_CH-1:0]    enable;
  logic                 div_wr;
  logic [CH_W-1:0]      div_ch;
  logic [CNT_WIDTH-1:0] div_value;
  logic                 sync_all;
  logic [NUM_CH-1:0]    div_pending;
  logic [NUM_CH-1:0]    clk_out;
  logic [NUM_CH-1:0]    tick;

  clkdiv_bank #(
    .NUM_CH      (NUM_CH),
    .CNT_WIDTH   (CNT_WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .enable      (enable),
    .div_wr      (div_wr),
    .div_ch      (div_ch),
    .div_value   (div_value),
    .sync_all    (sync_all),
    .div_pending (div_pending),
    .clk_out     (clk_out),
    .tick        (tick)
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: elapsed cycles in the current half-period, plus level and divisors.
  int m_el [NUM_CH];
  int m_hp [NUM_CH];
  int m_sh [NUM_CH];
  bit m_pnd[NUM_CH];
  bit m_clk[NUM_CH];
  bit m_tck[NUM_CH];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_el[c] = 0; m_hp[c] = DEFAULT_DIV; m_sh[c] = DEFAULT_DIV;
      m_pnd[c] = 0; m_clk[c] = 0; m_tck[c] = 0;
    end
  endtask

  task automatic model_step(input logic [NUM_CH-1:0] en, input logic wr, input logic [CH_W-1:0] ch,
                            input logic [CNT_WIDTH-1:0] val, input logic sync);
    int v;
    v = (val == 0) ? 1 : int'(val);
    for (int c = 0; c < NUM_CH; c++) begin
      bit w;
      bit ended;
      w = wr && (int'(ch) == c);
      ended = 0;
      m_tck[c] = 0;
      if (!sync && en[c] && !(w && `ifdef CLKDIV_IMMEDIATE_EN 1 `else 0 `endif)) begin
        if (m_el[c] + 1 >= m_hp[c]) begin
          m_el[c] = 0; m_clk[c] = !m_clk[c]; m_tck[c] = m_clk[c]; ended = 1;
        end else m_el[c]++;
      end
`ifdef CLKDIV_IMMEDIATE_EN
      if (sync) begin m_el[c] = 0; m_clk[c] = 0; end
      if (w) begin m_hp[c] = v; m_el[c] = 0; end
`else
      if (sync) begin
        if (m_pnd[c]) m_hp[c] = m_sh[c];
        m_pnd[c] = 0; m_el[c] = 0; m_clk[c] = 0;
      end else if (m_pnd[c] && !w && (ended || !en[c])) begin
        m_hp[c] = m_sh[c]; m_pnd[c] = 0;
      end
      if (w) begin m_sh[c] = v; m_pnd[c] = 1; end
`endif
    end
  endtask

  function automatic logic [NUM_CH-1:0] pk(input bit a[NUM_CH]);
    logic [NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = a[c];
    return r;
  endfunction

  // One clock: drive, edge, advance model, sample 1 time unit later and compare.
  task automatic cyc(input logic [NUM_CH-1:0] en, input logic wr, input logic [CH_W-1:0] ch,
                     input logic [CNT_WIDTH-1:0] val, input logic sync);
    enable = en; div_wr = wr; div_ch = ch; div_value = val; sync_all = sync;
    @(posedge clk_in);
    model_step(en, wr, ch, val, sync);
    #1;
    check("model_clk",  32'(clk_out),     32'(pk(m_clk)));
    check("model_tick", 32'(tick),        32'(pk(m_tck)));
    check("model_pend", 32'(div_pending), 32'(pk(m_pnd)));
  endtask

  typedef struct {
    logic [NUM_CH-1:0]    en;
    logic                 wr;
    logic [CH_W-1:0]      ch;
    logic [CNT_WIDTH-1:0] val;
    logic [NUM_CH-1:0]    e_clk;
    logic [NUM_CH-1:0]    e_tick;
    logic [NUM_CH-1:0]    e_pend;
  } vec_t;

  vec_t tbl[13];

  initial begin
    bit found;
    logic saved;
    int ntog, ntck;
    logic prev;

    tbl[0]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
    tbl[1]  = '{3'b111, 1'b1, 2'd0, 8'd2, 3'b000, 3'b000, 3'b001};
    tbl[2]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b001};
    tbl[3]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 3'b111, 3'b000};
    tbl[4]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 3'b000, 3'b000};
    tbl[5]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b110, 3'b000, 3'b000};
    tbl[6]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b110, 3'b000, 3'b000};
    tbl[7]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b001, 3'b001, 3'b000};
    tbl[8]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b001, 3'b000, 3'b000};
    tbl[9]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
    tbl[10] = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
    tbl[11] = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 3'b111, 3'b000};
    tbl[12] = '{3'b111, 1'b1, 2'd3, 8'd1, 3'b111, 3'b000, 3'b000};

    reset = 1'b0; enable = '1; div_wr = 0; div_ch = 0; div_value = 0; sync_all = 0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_clk",  32'(clk_out),     32'd0);
    check("rst_tick", 32'(tick),        32'd0);
    check("rst_pend", 32'(div_pending), 32'd0);
    reset = 1'b1;

    // Default period, shadowed write to ch0, ignored write to an absent channel.
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].en, tbl[i].wr, tbl[i].ch, tbl[i].val, 1'b0);
`ifndef CLKDIV_IMMEDIATE_EN
      check($sformatf("tbl%0d_clk", i),  32'(clk_out),     32'(tbl[i].e_clk));
      check($sformatf("tbl%0d_tick", i), 32'(tick),        32'(tbl[i].e_tick));
      check($sformatf("tbl%0d_pend", i), 32'(div_pending), 32'(tbl[i].e_pend));
`endif
    end

    // Zero divisor on ch1 behaves as hp=1.
    cyc('1, 1'b1, 2'd1, 8'd0, 1'b0);
    found = 0;
    for (int k = 0; k < 10; k++) begin
      if (!div_pending[1]) begin found = 1; break; end
      cyc('1, 1'b0, 2'd0, 8'd0, 1'b0);
    end
    check("hp1_applied", 32'(found), 32'd1);
    ntog = 0; ntck = 0;
    for (int k = 0; k < 8; k++) begin
      prev = clk_out[1];
      cyc('1, 1'b0, 2'd0, 8'd0, 1'b0);
      if (clk_out[1] != prev) ntog++;
      if (tick[1]) ntck++;
    end
    check("hp1_toggles", 32'(ntog), 32'd8);
    check("hp1_ticks",   32'(ntck), 32'd4);

    // Freeze ch0 at count 2 with hp=4.
    cyc('1, 1'b1, 2'd0, 8'd4, 1'b0);
    found = 0;
    for (int k = 0; k < 30; k++) begin
      cyc('1, 1'b0, 2'd0, 8'd0, 1'b0);
      if (tick[0] && !div_pending[0]) begin found = 1; break; end
    end
    check("frz_rise_found", 32'(found), 32'd1);
    cyc('1, 1'b0, 2'd0, 8'd0, 1'b0);
    cyc('1, 1'b0, 2'd0, 8'd0, 1'b0);
    saved = clk_out[0];
    for (int k = 0; k < 10; k++) begin
      cyc(3'b110, 1'b0, 2'd0, 8'd0, 1'b0);
      check("frz_clk",  32'(clk_out[0]), 32'(saved));
      check("frz_tick", 32'(tick[0]),    32'd0);
    end
    cyc('1, 1'b0, 2'd0, 8'd0, 1'b0);
    check("resume_hold", 32'(clk_out[0]), 32'(saved));
    cyc('1, 1'b0, 2'd0, 8'd0, 1'b0);
    check("resume_toggle", 32'(clk_out[0]), 32'(!saved));

    // sync_all with ch0 divisor 3 pending: in-phase restart.
    cyc('1, 1'b1, 2'd0, 8'd3, 1'b0);
    cyc('1, 1'b0, 2'd0, 8'd0, 1'b1);
    check("sync_clk",  32'(clk_out),     32'd0);
    check("sync_pend", 32'(div_pending), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      cyc('1, 1'b0, 2'd0, 8'd0, 1'b0);
      check($sformatf("sync_tick%0d", k), 32'(tick),
            32'({(k == 4) || (k == 12), (k % 2) == 1, (k == 3) || (k == 9)}));
    end

    // Asynchronous reset between edges.
    cyc('1, 1'b1, 2'd1, 8'd5, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("arst_clk",  32'(clk_out),     32'd0);
    check("arst_tick", 32'(tick),        32'd0);
    check("arst_pend", 32'(div_pending), 32'd0);
    model_reset();
    @(posedge clk_in);
    #1 reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc('1, 1'b0, 2'd0, 8'd0, 1'b0);
      check("arst_low", 32'(clk_out), 32'd0);
    end
    cyc('1, 1'b0, 2'd0, 8'd0, 1'b0);
    check("arst_rise",  32'(clk_out), 32'h7);
    check("arst_rtick", 32'(tick),    32'h7);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      logic [NUM_CH-1:0] en;
      for (int c = 0; c < NUM_CH; c++) en[c] = ($urandom_range(0, 9) != 0);
      cyc(en, ($urandom_range(0, 5) == 0), CH_W'($urandom_range(0, 3)),
          CNT_WIDTH'($urandom_range(0, 6)), ($urandom_range(0, 49) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
